// File: rtl/i2c_cfg_sequencer_if.sv
// Table/control/status bundle between an I2C configuration sequencer and its host.
// The sequencer takes the master modport; the host and table logic take the slave modport.
interface i2c_cfg_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             iSTART;
    logic [IDX_W-1:0] oIDX;
    logic [23:0]      iENTRY;
    logic             oBUSY;
    logic             oDONE;
    logic             oERR;
    logic [IDX_W-1:0] oERR_IDX;

    modport master (
        input  iSTART, iENTRY,
        output oIDX, oBUSY, oDONE, oERR, oERR_IDX
    );

    modport slave (
        output iSTART, iENTRY,
        input  oIDX, oBUSY, oDONE, oERR, oERR_IDX
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Power-up register loader: walks a {dev,sub,data} table and issues each entry as a
// 3-byte I2C write, retrying NACKed entries and reporting completion or abort.
module i2c_cfg_sequencer #(
    parameter int CLK_FREQ    = 50000000,
    parameter int I2C_FREQ    = 100000,
    parameter int NUM_ENTRIES = 51,
    parameter int IDX_W       = 6,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_START  = 1,
    parameter int GAP_TICKS   = 8
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    i2c_cfg_sequencer_if.master cfg,
    output logic                I2C_SCLK,
    inout  wire                 I2C_SDAT
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [QW-1:0]    QLAST    = QW'(QDIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RW-1:0]    RLIM     = RW'(MAX_RETRY);
    localparam logic [GW-1:0]    GLAST    = GW'(GAP_TICKS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BYTE  = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    logic [2:0]       r_state;
    logic [QW-1:0]    r_qcnt;
    logic             w_tick;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [1:0]       r_byte;
    logic [23:0]      r_shift;
    logic             r_nack;
    logic [RW-1:0]    r_retry;
    logic [GW-1:0]    r_gap;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [IDX_W-1:0] r_err_idx;
    logic             r_scl;
    logic             r_sda_oe;
    logic             r_sda_s1;
    logic             r_sda_s2;
    logic             r_auto;

    assign w_tick       = (r_qcnt == QLAST);
    assign cfg.oIDX     = r_idx;
    assign cfg.oBUSY    = r_busy;
    assign cfg.oDONE    = r_done;
    assign cfg.oERR     = r_err;
    assign cfg.oERR_IDX = r_err_idx;
    assign I2C_SCLK     = r_scl;
    assign I2C_SDAT     = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_qcnt   <= '0;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_qcnt   <= w_tick ? '0 : r_qcnt + QW'(1);
            r_sda_s1 <= I2C_SDAT;
            r_sda_s2 <= r_sda_s1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_nack    <= 1'b0;
            r_retry   <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_auto    <= (AUTO_START != 0);
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg.iSTART || r_auto) begin
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_retry <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift <= cfg.iENTRY;
                    r_nack  <= 1'b0;
                    r_q     <= '0;
                    r_state <= S_START;
                end
                S_START: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd1: r_sda_oe <= 1'b1;
                        2'd2: begin
                            r_scl   <= 1'b0;
                            r_q     <= '0;
                            r_bit   <= '0;
                            r_byte  <= '0;
                            r_state <= S_BYTE;
                        end
                        default: ;
                    endcase
                end
                // Quarter phases: q0 drive SDA, q1 SCL high, q2 (sample), q3 SCL low.
                S_BYTE: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sda_oe <= ~r_shift[23];
                        2'd1: r_scl <= 1'b1;
                        2'd3: begin
                            r_scl   <= 1'b0;
                            r_shift <= {r_shift[22:0], 1'b0};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7)
                                r_state <= S_ACK;
                        end
                        default: ;
                    endcase
                end
                S_ACK: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sda_oe <= 1'b0;
                        2'd1: r_scl <= 1'b1;
                        2'd2: r_nack <= r_sda_s2;
                        default: begin
                            r_scl <= 1'b0;
                            if (r_nack || r_byte == 2'd2) begin
                                r_state <= S_STOP;
                            end else begin
                                r_byte  <= r_byte + 2'd1;
                                r_state <= S_BYTE;
                            end
                        end
                    endcase
                end
                S_STOP: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sda_oe <= 1'b1;
                        2'd1: r_scl <= 1'b1;
                        2'd2: begin
                            r_sda_oe <= 1'b0;
                            r_q      <= '0;
                            r_gap    <= '0;
                            r_state  <= S_GAP;
                        end
                        default: ;
                    endcase
                end
                S_GAP: if (w_tick) begin
                    if (r_gap != GLAST) begin
                        r_gap <= r_gap + GW'(1);
                    end else if (!r_nack) begin
                        r_retry <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_LOAD;
                        end
                    end else if (r_retry < RLIM) begin
                        r_retry <= r_retry + RW'(1);
                        r_state <= S_LOAD;
                    end else begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_idx;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: an I2C slave model at 8'h34 logs each transfer and checks it
// against a queue of expected transfers; a second instance covers manual start, 1 entry, no retry.
module tb_i2c_cfg_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_cfg_sequencer_if #(.IDX_W(6)) bus1();
    i2c_cfg_sequencer_if #(.IDX_W(6)) bus2();

    logic scl1, scl2;
    wire  sda1, sda2;
    logic s_drive = 1'b0;
    pullup (sda1);
    pullup (sda2);
    assign sda1 = s_drive ? 1'b0 : 1'bz;

    i2c_cfg_sequencer #(
        .CLK_FREQ(400), .I2C_FREQ(10), .NUM_ENTRIES(3), .IDX_W(6),
        .MAX_RETRY(2), .AUTO_START(1), .GAP_TICKS(8)
    ) u_dut (
        .iCLK(clk), .iRST_N(rst_n), .cfg(bus1), .I2C_SCLK(scl1), .I2C_SDAT(sda1)
    );

    i2c_cfg_sequencer #(
        .CLK_FREQ(400), .I2C_FREQ(10), .NUM_ENTRIES(1), .IDX_W(6),
        .MAX_RETRY(0), .AUTO_START(0), .GAP_TICKS(2)
    ) u_dut2 (
        .iCLK(clk), .iRST_N(rst_n), .cfg(bus2), .I2C_SCLK(scl2), .I2C_SDAT(sda2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [23:0] tbl [0:63];
    logic [31:0] exp_q [$];
    always_comb bus1.iENTRY = tbl[bus1.oIDX];
    assign bus2.iENTRY = 24'h34001F;

    // Slave model on bus 1: decodes START/STOP, commits a bit on SCL fall, ACKs address 8'h34.
    logic [7:0]  nack_sub = 8'h00;
    int          nack_limit = 0;
    int          s_nack_seen = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1, s_bit = 1'b0, s_have = 1'b0, s_in = 1'b0, s_ack;
    int          s_bitcnt = 0, s_nbytes = 0, proto_err = 0;
    logic [7:0]  s_sh = 8'h00;
    logic [7:0]  s_b [0:2];
    logic [31:0] obs;

    always @(scl1 or sda1 or rst_n) begin
        if (!rst_n) begin
            s_in    = 1'b0;
            s_drive = 1'b0;
            s_have  = 1'b0;
        end else if (scl1 && p_scl && p_sda && !sda1) begin
            if (s_in) proto_err++;
            s_in = 1'b1; s_bitcnt = 0; s_nbytes = 0; s_have = 1'b0;
            s_b[0] = 8'h00; s_b[1] = 8'h00; s_b[2] = 8'h00;
        end else if (scl1 && p_scl && !p_sda && sda1) begin
            if (!s_in || s_bitcnt != 0) begin
                proto_err++;
            end else begin
                obs = {8'(s_nbytes), s_b[0], s_b[1], s_b[2]};
                if (exp_q.size() == 0) check_val("extra_xfer", obs, 32'h0);
                else check_val("xfer", obs, exp_q.pop_front());
            end
            s_in = 1'b0;
        end else if (scl1 && !p_scl) begin
            s_bit  = sda1;
            s_have = s_in;
        end else if (!scl1 && p_scl && s_have) begin
            s_have = 1'b0;
            if (s_bitcnt < 8) begin
                s_sh = {s_sh[6:0], s_bit};
                s_bitcnt++;
                if (s_bitcnt == 8) begin
                    if (s_nbytes < 3) s_b[s_nbytes] = s_sh;
                    case (s_nbytes)
                        0: s_ack = (s_sh == 8'h34);
                        1: begin
                            s_ack = !(s_sh == nack_sub && s_nack_seen < nack_limit);
                            if (!s_ack) s_nack_seen++;
                        end
                        default: s_ack = 1'b1;
                    endcase
                    s_drive = s_ack;
                end
            end else begin
                s_drive  = 1'b0;
                s_bitcnt = 0;
                s_nbytes++;
            end
        end
        p_scl = scl1;
        p_sda = sda1;
    end

    int act2 = 0;
    always @(negedge scl2) act2++;

    task automatic push_run();
        for (int i = 0; i < 3; i++) exp_q.push_back({8'd3, tbl[i]});
    endtask

    task automatic pulse_start1();
        @(negedge clk); bus1.iSTART = 1'b1;
        @(negedge clk); bus1.iSTART = 1'b0;
    endtask

    task automatic wait_idle1(input int budget);
        int n = 0;
        while (bus1.oBUSY && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus1.oBUSY) check_val("run_timeout", 32'(bus1.oBUSY), 32'h0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        bus1.iSTART = 1'b0;
        bus2.iSTART = 1'b0;
        for (int i = 0; i < 64; i++) tbl[i] = 24'h000000;
        tbl[0] = 24'h34001F;
        tbl[1] = 24'h34047A;
        tbl[2] = 24'h341201;
        push_run();

        // Reset state
        #22;
        check_val("rst_busy", 32'(bus1.oBUSY), 32'h0);
        check_val("rst_done", 32'(bus1.oDONE), 32'h0);
        check_val("rst_err", 32'(bus1.oERR), 32'h0);
        check_val("rst_idx", 32'(bus1.oIDX), 32'h0);
        check_val("rst_scl", 32'(scl1), 32'h1);
        check_val("rst_sda", 32'(sda1), 32'h1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_val("auto_busy", 32'(bus1.oBUSY), 32'h1);

        // 1: automatic run, all ACKed
        wait_idle1(20000);
        check_val("t1_done", 32'(bus1.oDONE), 32'h1);
        check_val("t1_err", 32'(bus1.oERR), 32'h0);
        check_val("t1_idx", 32'(bus1.oIDX), 32'd2);
        check_val("t1_q", 32'(exp_q.size()), 32'h0);

        // 2: sub-addr NACKed twice at index 1, third attempt succeeds
        nack_sub = 8'h04;
        nack_limit = 2;
        exp_q.push_back({8'd3, tbl[0]});
        exp_q.push_back({8'd2, tbl[1][23:8], 8'h00});
        exp_q.push_back({8'd2, tbl[1][23:8], 8'h00});
        exp_q.push_back({8'd3, tbl[1]});
        exp_q.push_back({8'd3, tbl[2]});
        pulse_start1();
        check_val("t2_done_clr", 32'(bus1.oDONE), 32'h0);
        wait_idle1(30000);
        check_val("t2_done", 32'(bus1.oDONE), 32'h1);
        check_val("t2_err", 32'(bus1.oERR), 32'h0);
        check_val("t2_nacks", 32'(s_nack_seen), 32'd2);
        check_val("t2_q", 32'(exp_q.size()), 32'h0);

        // 3: no slave at 8'h40, retries exhausted on index 0
        tbl[0] = 24'h40001F;
        for (int i = 0; i < 3; i++) exp_q.push_back({8'd1, 8'h40, 16'h0000});
        pulse_start1();
        wait_idle1(20000);
        check_val("t3_err", 32'(bus1.oERR), 32'h1);
        check_val("t3_err_idx", 32'(bus1.oERR_IDX), 32'h0);
        check_val("t3_done", 32'(bus1.oDONE), 32'h0);
        check_val("t3_idx", 32'(bus1.oIDX), 32'h0);
        wait_cycles(1500);
        check_val("t3_q", 32'(exp_q.size()), 32'h0);

        // 4: restart clears the error; a second start mid-run is ignored
        tbl[0] = 24'h34001F;
        push_run();
        pulse_start1();
        check_val("t4_err_clr", 32'(bus1.oERR), 32'h0);
        check_val("t4_busy", 32'(bus1.oBUSY), 32'h1);
        wait_cycles(1500);
        pulse_start1();
        wait_idle1(20000);
        check_val("t4_done", 32'(bus1.oDONE), 32'h1);
        wait_cycles(1500);
        check_val("t4_idle", 32'(bus1.oBUSY), 32'h0);
        check_val("t4_q", 32'(exp_q.size()), 32'h0);

        // 5: reset in the middle of the address byte
        pulse_start1();
        n = 0;
        while (!(s_in && s_nbytes == 0 && s_bitcnt == 4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_reach", 32'(s_bitcnt), 32'd4);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_val("t5_scl", 32'(scl1), 32'h1);
        check_val("t5_sda", 32'(sda1), 32'h1);
        check_val("t5_busy", 32'(bus1.oBUSY), 32'h0);
        check_val("t5_done", 32'(bus1.oDONE), 32'h0);
        check_val("t5_idx", 32'(bus1.oIDX), 32'h0);
        wait_cycles(3);
        push_run();
        rst_n = 1'b1;
        wait_cycles(2);
        check_val("t5_restart", 32'(bus1.oBUSY), 32'h1);
        wait_idle1(20000);
        check_val("t5_done_end", 32'(bus1.oDONE), 32'h1);
        check_val("t5_q", 32'(exp_q.size()), 32'h0);

        // 6: manual-start instance, one entry, abort on first NACK
        check_val("t6_quiet", 32'(act2), 32'h0);
        @(negedge clk); bus2.iSTART = 1'b1;
        @(negedge clk); bus2.iSTART = 1'b0;
        n = 0;
        while (bus2.oBUSY && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_busy", 32'(bus2.oBUSY), 32'h0);
        check_val("t6_err", 32'(bus2.oERR), 32'h1);
        check_val("t6_err_idx", 32'(bus2.oERR_IDX), 32'h0);
        check_val("t6_done", 32'(bus2.oDONE), 32'h0);
        check_val("t6_scl_falls", 32'(act2), 32'd10);
        check_val("proto", 32'(proto_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
